// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and widths for the two-master Wishbone RAM arbiter
package wb_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;
    localparam int HOLD_W = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WIDTH_W = 2;
endpackage

// File: rtl/WISHBONE_IF.sv
// WISHBONE_IF: single-beat Wishbone bundle between a requester and the RAMBlock port
interface WISHBONE_IF;
    import wb_arb_pkg::*;
    logic stb;
    logic cyc;
    logic we;
    logic ack;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH_W-1:0] width;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    modport master(output stb, cyc, we, addr, width, data_write, input data_read, ack);
    modport slave(input stb, cyc, we, addr, width, data_write, output data_read, ack);
endinterface

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick: fairness rule choosing the next grant from idle
module wb_arb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    output arb_state_t pick
);
    // ptr=0 favours m0, ptr=1 favours m1; it only matters under contention
    always_comb pick = (req0 & req1) ? (ptr ? ARB_GNT1 : ARB_GNT0) :
                       req0 ? ARB_GNT0 : req1 ? ARB_GNT1 : ARB_IDLE;
endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: locks the RAMBlock port to one of two Wishbone masters per cyc,
// round-robin under contention, with a hold limit so neither master starves.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter bit M0_FIRST = 1'b1
) (
    input logic        iClk,
    input logic        iRst,
    WISHBONE_IF.slave  m0_wb,
    WISHBONE_IF.slave  m1_wb,
    WISHBONE_IF.master s_wb
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    arb_state_t state, state_next, pick;
    logic ptr, ptr_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic req0, req1, gnt0, gnt1, other_req, at_limit, preempt, release_gnt;
    assign req0 = m0_wb.cyc & m0_wb.stb;
    assign req1 = m1_wb.cyc & m1_wb.stb;
    assign gnt0 = state == ARB_GNT0;
    assign gnt1 = state == ARB_GNT1;
    assign other_req = gnt0 ? req1 : gnt1 ? req0 : 1'b0;
    assign at_limit = hold_cnt == HOLD_LAST;
    assign preempt = s_wb.ack & at_limit & other_req;
    assign release_gnt = gnt0 ? (~m0_wb.cyc | preempt) : gnt1 ? (~m1_wb.cyc | preempt) : 1'b0;
    wb_arb_rr_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .ptr  (ptr),
        .pick (pick)
    );
    always_comb begin
        state_next = state;
        ptr_next = ptr;
        hold_next = hold_cnt;
        if (state == ARB_IDLE)
            state_next = pick;
        else if (release_gnt) begin
            // hand over directly when the other side waits, so no idle bubble
            state_next = other_req ? (gnt0 ? ARB_GNT1 : ARB_GNT0) : ARB_IDLE;
            ptr_next = gnt0;
        end
        if (state_next != state)
            hold_next = '0;
        else if (s_wb.ack & other_req & ~at_limit)
            hold_next = hold_cnt + 1'b1;
    end
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= ARB_IDLE;
            ptr <= ~M0_FIRST;
            hold_cnt <= '0;
        end else begin
            state <= state_next;
            ptr <= ptr_next;
            hold_cnt <= hold_next;
        end
    end
    // grant comes straight from the state flop, so reset drops the slave side at once
    assign s_wb.stb = gnt0 ? m0_wb.stb : gnt1 ? m1_wb.stb : 1'b0;
    assign s_wb.cyc = gnt0 ? m0_wb.cyc : gnt1 ? m1_wb.cyc : 1'b0;
    assign s_wb.we = gnt0 ? m0_wb.we : gnt1 ? m1_wb.we : 1'b0;
    assign s_wb.addr = gnt0 ? m0_wb.addr : gnt1 ? m1_wb.addr : '0;
    assign s_wb.width = gnt0 ? m0_wb.width : gnt1 ? m1_wb.width : '0;
    assign s_wb.data_write = gnt0 ? m0_wb.data_write : gnt1 ? m1_wb.data_write : '0;
    assign m0_wb.ack = gnt0 & s_wb.ack;
    assign m1_wb.ack = gnt1 & s_wb.ack;
    assign m0_wb.data_read = gnt0 ? s_wb.data_read : '0;
    assign m1_wb.data_read = gnt1 ? s_wb.data_read : '0;
endmodule
